// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared sizes, resource layout and lane decoders for the hazard scoreboard.
package reg_scoreboard_pkg;
  localparam int CNT_W   = 2;
  localparam int NUM_GPR = 8;
  localparam int NUM_SEG = 8;
  localparam int NUM_MM  = 8;
  localparam int ID_W    = 3;
  localparam int FLG_ZF  = 0;
  localparam int FLG_AF  = 1;
  localparam int FLG_DF  = 2;
  localparam int FLG_CF  = 3;
  localparam int NUM_FLG = 4;
  localparam int GPR_LANES = NUM_GPR * 4;
  // Flat resource layout: GPR lanes, then seg, MM, flags, and the single memory counter on top.
  localparam int SEG_LO  = GPR_LANES;
  localparam int MM_LO   = SEG_LO + NUM_SEG;
  localparam int FLG_LO  = MM_LO + NUM_MM;
  localparam int MEM_BIT = FLG_LO + NUM_FLG;
  localparam int NUM_RES = MEM_BIT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [GPR_LANES-1:0] gpr_lanes(input logic en, input logic [ID_W-1:0] id,
                                                     input logic [3:0] strb);
    return en ? GPR_LANES'(strb) << {id, 2'b00} : '0;
  endfunction

  function automatic logic [NUM_SEG-1:0] onehot(input logic en, input logic [ID_W-1:0] id);
    return en ? NUM_SEG'(1) << id : '0;
  endfunction
endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: saturating pending-writer counter; clr wins, simultaneous inc and dec cancel.
module sb_counter import reg_scoreboard_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic at_max,
  output logic nonzero,
  output logic underflow
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign at_max    = cnt_q == CNT_MAX;
  assign nonzero   = cnt_q != '0;
  assign underflow = dec & ~clr & ~nonzero;
  always_comb begin
    cnt_d = clr                      ? '0 :
            (inc & ~dec & ~at_max)   ? cnt_q + 1'b1 :
            (dec & ~inc & nonzero)   ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight writers per GPR lane/seg/MM/flag/memory and stalls register read on hazards.
module reg_scoreboard import reg_scoreboard_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            iss_valid,
  input  logic            iss_ld_reg1,
  input  logic            iss_ld_reg2,
  input  logic            iss_ld_reg3,
  input  logic [ID_W-1:0] iss_reg1_id,
  input  logic [ID_W-1:0] iss_reg2_id,
  input  logic [ID_W-1:0] iss_reg3_id,
  input  logic [3:0]      iss_reg1_strb,
  input  logic [3:0]      iss_reg2_strb,
  input  logic [3:0]      iss_reg3_strb,
  input  logic            iss_ld_seg,
  input  logic [ID_W-1:0] iss_seg_id,
  input  logic            iss_ld_mm,
  input  logic [ID_W-1:0] iss_mm_id,
  input  logic            iss_ld_mem,
  input  logic [3:0]      iss_ld_flag,
  input  logic            rd_reg1_en,
  input  logic            rd_reg2_en,
  input  logic [ID_W-1:0] rd_reg1_id,
  input  logic [ID_W-1:0] rd_reg2_id,
  input  logic [3:0]      rd_reg1_strb,
  input  logic [3:0]      rd_reg2_strb,
  input  logic            rd_seg_en,
  input  logic [ID_W-1:0] rd_seg_id,
  input  logic            rd_mm1_en,
  input  logic            rd_mm2_en,
  input  logic [ID_W-1:0] rd_mm1_id,
  input  logic [ID_W-1:0] rd_mm2_id,
  input  logic            rd_mem,
  input  logic [3:0]      rd_flag,
  input  logic            wb_valid,
  input  logic            wb_ld_reg1,
  input  logic            wb_ld_reg2,
  input  logic            wb_ld_reg3,
  input  logic [ID_W-1:0] wb_reg1_id,
  input  logic [ID_W-1:0] wb_reg2_id,
  input  logic [ID_W-1:0] wb_reg3_id,
  input  logic [3:0]      wb_reg1_strb,
  input  logic [3:0]      wb_reg2_strb,
  input  logic [3:0]      wb_reg3_strb,
  input  logic            wb_ld_seg,
  input  logic [ID_W-1:0] wb_seg_id,
  input  logic            wb_ld_mm,
  input  logic [ID_W-1:0] wb_mm_id,
  input  logic            wb_ld_mem,
  input  logic [3:0]      wb_ld_flag,
  output logic            stall,
  output logic            iss_ack,
  output logic            sb_err
);
  logic [NUM_RES-1:0] iss_vec, wb_vec, rd_vec, inc, dec, at_max, nonzero, underflow;
  logic               sb_err_q, sb_err_d;
  // Overlapping destinations OR together, so a lane hit twice moves by one.
  assign iss_vec = {iss_ld_mem, iss_ld_flag, onehot(iss_ld_mm, iss_mm_id), onehot(iss_ld_seg, iss_seg_id),
                    gpr_lanes(iss_ld_reg1, iss_reg1_id, iss_reg1_strb) |
                    gpr_lanes(iss_ld_reg2, iss_reg2_id, iss_reg2_strb) |
                    gpr_lanes(iss_ld_reg3, iss_reg3_id, iss_reg3_strb)};
  assign wb_vec  = {wb_ld_mem, wb_ld_flag, onehot(wb_ld_mm, wb_mm_id), onehot(wb_ld_seg, wb_seg_id),
                    gpr_lanes(wb_ld_reg1, wb_reg1_id, wb_reg1_strb) |
                    gpr_lanes(wb_ld_reg2, wb_reg2_id, wb_reg2_strb) |
                    gpr_lanes(wb_ld_reg3, wb_reg3_id, wb_reg3_strb)};
  assign rd_vec  = {rd_mem, rd_flag, onehot(rd_mm1_en, rd_mm1_id) | onehot(rd_mm2_en, rd_mm2_id),
                    onehot(rd_seg_en, rd_seg_id),
                    gpr_lanes(rd_reg1_en, rd_reg1_id, rd_reg1_strb) |
                    gpr_lanes(rd_reg2_en, rd_reg2_id, rd_reg2_strb)};
  assign stall   = (|(rd_vec & nonzero)) | (iss_valid & (|(iss_vec & at_max)));
  assign iss_ack = iss_valid & ~stall;
  assign inc     = iss_ack  ? iss_vec : '0;
  assign dec     = wb_valid ? wb_vec  : '0;
  assign sb_err  = sb_err_q;
  for (genvar i = 0; i < NUM_RES; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .clr       (flush),
      .at_max    (at_max[i]),
      .nonzero   (nonzero[i]),
      .underflow (underflow[i])
    );
  end
  always_comb begin
    sb_err_d = sb_err_q | (|underflow);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_err_q <= 1'b0;
    else        sb_err_q <= sb_err_d;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks of reg_scoreboard against a per-resource count model.
module tb_reg_scoreboard;
  logic clk = 1'b0, rst_n = 1'b0, flush;
  logic iss_valid, iss_ld_reg1, iss_ld_reg2, iss_ld_reg3, iss_ld_seg, iss_ld_mm, iss_ld_mem;
  logic [2:0] iss_reg1_id, iss_reg2_id, iss_reg3_id, iss_seg_id, iss_mm_id;
  logic [3:0] iss_reg1_strb, iss_reg2_strb, iss_reg3_strb, iss_ld_flag;
  logic rd_reg1_en, rd_reg2_en, rd_seg_en, rd_mm1_en, rd_mm2_en, rd_mem;
  logic [2:0] rd_reg1_id, rd_reg2_id, rd_seg_id, rd_mm1_id, rd_mm2_id;
  logic [3:0] rd_reg1_strb, rd_reg2_strb, rd_flag;
  logic wb_valid, wb_ld_reg1, wb_ld_reg2, wb_ld_reg3, wb_ld_seg, wb_ld_mm, wb_ld_mem;
  logic [2:0] wb_reg1_id, wb_reg2_id, wb_reg3_id, wb_seg_id, wb_mm_id;
  logic [3:0] wb_reg1_strb, wb_reg2_strb, wb_reg3_strb, wb_ld_flag;
  logic stall, iss_ack, sb_err;
  int tests = 0, fails = 0;
  int gpr[8][4];
  int seg[8], mm[8], flg[4];
  int mem_c;
  bit err;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .iss_valid(iss_valid),
    .iss_ld_reg1(iss_ld_reg1), .iss_ld_reg2(iss_ld_reg2), .iss_ld_reg3(iss_ld_reg3),
    .iss_reg1_id(iss_reg1_id), .iss_reg2_id(iss_reg2_id), .iss_reg3_id(iss_reg3_id),
    .iss_reg1_strb(iss_reg1_strb), .iss_reg2_strb(iss_reg2_strb), .iss_reg3_strb(iss_reg3_strb),
    .iss_ld_seg(iss_ld_seg), .iss_seg_id(iss_seg_id), .iss_ld_mm(iss_ld_mm), .iss_mm_id(iss_mm_id),
    .iss_ld_mem(iss_ld_mem), .iss_ld_flag(iss_ld_flag),
    .rd_reg1_en(rd_reg1_en), .rd_reg2_en(rd_reg2_en), .rd_reg1_id(rd_reg1_id), .rd_reg2_id(rd_reg2_id),
    .rd_reg1_strb(rd_reg1_strb), .rd_reg2_strb(rd_reg2_strb), .rd_seg_en(rd_seg_en), .rd_seg_id(rd_seg_id),
    .rd_mm1_en(rd_mm1_en), .rd_mm2_en(rd_mm2_en), .rd_mm1_id(rd_mm1_id), .rd_mm2_id(rd_mm2_id),
    .rd_mem(rd_mem), .rd_flag(rd_flag), .wb_valid(wb_valid),
    .wb_ld_reg1(wb_ld_reg1), .wb_ld_reg2(wb_ld_reg2), .wb_ld_reg3(wb_ld_reg3),
    .wb_reg1_id(wb_reg1_id), .wb_reg2_id(wb_reg2_id), .wb_reg3_id(wb_reg3_id),
    .wb_reg1_strb(wb_reg1_strb), .wb_reg2_strb(wb_reg2_strb), .wb_reg3_strb(wb_reg3_strb),
    .wb_ld_seg(wb_ld_seg), .wb_seg_id(wb_seg_id), .wb_ld_mm(wb_ld_mm), .wb_mm_id(wb_mm_id),
    .wb_ld_mem(wb_ld_mem), .wb_ld_flag(wb_ld_flag),
    .stall(stall), .iss_ack(iss_ack), .sb_err(sb_err)
  );

  task automatic idle();
    flush = 0; iss_valid = 0; wb_valid = 0;
    {iss_ld_reg1, iss_ld_reg2, iss_ld_reg3, iss_ld_seg, iss_ld_mm, iss_ld_mem} = '0;
    {iss_reg1_id, iss_reg2_id, iss_reg3_id, iss_seg_id, iss_mm_id} = '0;
    {iss_reg1_strb, iss_reg2_strb, iss_reg3_strb, iss_ld_flag} = '0;
    {rd_reg1_en, rd_reg2_en, rd_seg_en, rd_mm1_en, rd_mm2_en, rd_mem} = '0;
    {rd_reg1_id, rd_reg2_id, rd_seg_id, rd_mm1_id, rd_mm2_id} = '0;
    {rd_reg1_strb, rd_reg2_strb, rd_flag} = '0;
    {wb_ld_reg1, wb_ld_reg2, wb_ld_reg3, wb_ld_seg, wb_ld_mm, wb_ld_mem} = '0;
    {wb_reg1_id, wb_reg2_id, wb_reg3_id, wb_seg_id, wb_mm_id} = '0;
    {wb_reg1_strb, wb_reg2_strb, wb_reg3_strb, wb_ld_flag} = '0;
  endtask

  function automatic void clear_model();
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 4; b++) gpr[r][b] = 0;
      seg[r] = 0; mm[r] = 0;
    end
    for (int f = 0; f < 4; f++) flg[f] = 0;
    mem_c = 0;
  endfunction

  function automatic bit hit(logic ld, logic [2:0] id, logic [3:0] strb, int r, int b);
    return ld && id == r && strb[b];
  endfunction

  function automatic bit iss_g(int r, int b);
    return hit(iss_ld_reg1, iss_reg1_id, iss_reg1_strb, r, b) || hit(iss_ld_reg2, iss_reg2_id, iss_reg2_strb, r, b)
        || hit(iss_ld_reg3, iss_reg3_id, iss_reg3_strb, r, b);
  endfunction

  function automatic bit wb_g(int r, int b);
    return hit(wb_ld_reg1, wb_reg1_id, wb_reg1_strb, r, b) || hit(wb_ld_reg2, wb_reg2_id, wb_reg2_strb, r, b)
        || hit(wb_ld_reg3, wb_reg3_id, wb_reg3_strb, r, b);
  endfunction

  // Stall from the rules: a pending writer on any source, or any issue destination already full.
  function automatic bit exp_stall();
    bit s = 0;
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 4; b++) begin
        if (gpr[r][b] > 0 && (hit(rd_reg1_en, rd_reg1_id, rd_reg1_strb, r, b) ||
                              hit(rd_reg2_en, rd_reg2_id, rd_reg2_strb, r, b))) s = 1;
        if (iss_valid && gpr[r][b] == 3 && iss_g(r, b)) s = 1;
      end
      if (seg[r] > 0 && rd_seg_en && rd_seg_id == r) s = 1;
      if (mm[r] > 0 && ((rd_mm1_en && rd_mm1_id == r) || (rd_mm2_en && rd_mm2_id == r))) s = 1;
      if (iss_valid && iss_ld_seg && iss_seg_id == r && seg[r] == 3) s = 1;
      if (iss_valid && iss_ld_mm && iss_mm_id == r && mm[r] == 3) s = 1;
    end
    for (int f = 0; f < 4; f++) begin
      if (rd_flag[f] && flg[f] > 0) s = 1;
      if (iss_valid && iss_ld_flag[f] && flg[f] == 3) s = 1;
    end
    if (rd_mem && mem_c > 0) s = 1;
    if (iss_valid && iss_ld_mem && mem_c == 3) s = 1;
    return s;
  endfunction

  function automatic bit would_underflow();
    bit u = 0;
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 4; b++) if (wb_g(r, b) && gpr[r][b] == 0) u = 1;
      if (wb_ld_seg && wb_seg_id == r && seg[r] == 0) u = 1;
      if (wb_ld_mm && wb_mm_id == r && mm[r] == 0) u = 1;
    end
    for (int f = 0; f < 4; f++) if (wb_ld_flag[f] && flg[f] == 0) u = 1;
    if (wb_ld_mem && mem_c == 0) u = 1;
    return u;
  endfunction

  function automatic void upd(inout int c, input bit i, input bit d);
    if (d && c == 0) err = 1;
    else if (i && !d) c++;
    else if (d && !i) c--;
  endfunction

  // One clock: the model moves by the issue/release events present before the edge.
  task automatic cycle();
    bit ack, w;
    ack = iss_valid && !exp_stall();
    w = wb_valid;
    @(posedge clk);
    if (flush) clear_model();
    else begin
      for (int r = 0; r < 8; r++) begin
        for (int b = 0; b < 4; b++) upd(gpr[r][b], ack && iss_g(r, b), w && wb_g(r, b));
        upd(seg[r], ack && iss_ld_seg && iss_seg_id == r, w && wb_ld_seg && wb_seg_id == r);
        upd(mm[r], ack && iss_ld_mm && iss_mm_id == r, w && wb_ld_mm && wb_mm_id == r);
      end
      for (int f = 0; f < 4; f++) upd(flg[f], ack && iss_ld_flag[f], w && wb_ld_flag[f]);
      upd(mem_c, ack && iss_ld_mem, w && wb_ld_mem);
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    clear_model();
    err = 0;
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests++; if (sb_err !== 1'b0) begin fails++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    iss_valid = 1; #1;
    tests++; if (iss_ack !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL reset_ack got ack=%b stall=%b exp 1/0", iss_ack, stall); end
    idle();
  endtask

  task automatic test_gpr_raw();
    iss_valid = 1; iss_ld_reg1 = 1; iss_reg1_id = 3; iss_reg1_strb = 4'b0011; #1;
    tests++; if (iss_ack !== 1'b1) begin fails++; $display("FAIL gpr_issue_ack got %b exp 1", iss_ack); end
    cycle(); idle();
    rd_reg1_en = 1; rd_reg1_id = 3; rd_reg1_strb = 4'b0001; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL gpr_raw_lane0 got %b exp 1", stall); end
    rd_reg1_strb = 4'b0100; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL gpr_other_lane got %b exp 0", stall); end
    rd_reg1_strb = 4'b0001; wb_valid = 1; wb_ld_reg1 = 1; wb_reg1_id = 3; wb_reg1_strb = 4'b0011; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL gpr_release_no_bypass got %b exp 1", stall); end
    cycle();
    wb_valid = 0; wb_ld_reg1 = 0; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL gpr_released got %b exp 0", stall); end
    idle();
  endtask

  task automatic test_flag_same_cycle();
    iss_valid = 1; iss_ld_flag = 4'b1000; cycle();
    wb_valid = 1; wb_ld_flag = 4'b1000; cycle();
    idle(); rd_flag = 4'b1000; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flag_cf_held got %b exp 1", stall); end
    wb_valid = 1; wb_ld_flag = 4'b1000; cycle();
    wb_valid = 0; wb_ld_flag = 0; #1;
    tests++; if (stall !== 1'b0 || sb_err !== 1'b0) begin fails++; $display("FAIL flag_cf_one got stall=%b err=%b exp 0/0", stall, sb_err); end
    idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1; iss_ld_mm = 1; iss_mm_id = 2; #1;
      tests++; if (iss_ack !== 1'b1) begin fails++; $display("FAIL mm_fill_%0d got ack %b exp 1", k, iss_ack); end
      cycle();
    end
    #1;
    tests++; if (stall !== 1'b1 || iss_ack !== 1'b0) begin fails++; $display("FAIL mm_saturate got stall=%b ack=%b exp 1/0", stall, iss_ack); end
    cycle(); idle();
    rd_mm2_en = 1; rd_mm2_id = 2;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_ld_mm = 1; wb_mm_id = 2; cycle();
      wb_valid = 0; #1;
      tests++; if (stall !== (k < 2)) begin fails++; $display("FAIL mm_drain_%0d got %b exp %b", k, stall, k < 2); end
    end
    tests++; if (sb_err !== 1'b0) begin fails++; $display("FAIL mm_no_err got %b exp 0", sb_err); end
    idle();
  endtask

  task automatic test_sb_err();
    wb_valid = 1; wb_ld_seg = 1; wb_seg_id = 4; #1;
    tests++; if (sb_err !== 1'b0) begin fails++; $display("FAIL err_not_yet got %b exp 0", sb_err); end
    cycle(); idle(); #1;
    tests++; if (sb_err !== 1'b1) begin fails++; $display("FAIL err_set got %b exp 1", sb_err); end
    iss_valid = 1; iss_ld_seg = 1; iss_seg_id = 4; cycle();
    idle(); wb_valid = 1; wb_ld_seg = 1; wb_seg_id = 4; cycle();
    idle(); flush = 1; cycle(); idle(); #1;
    tests++; if (sb_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", sb_err); end
  endtask

  task automatic test_flush();
    iss_valid = 1; iss_ld_reg1 = 1; iss_reg1_id = 0; iss_reg1_strb = 4'b0001; cycle(); cycle();
    idle(); iss_valid = 1; iss_ld_mem = 1; cycle();
    idle(); rd_reg1_en = 1; rd_reg1_id = 0; rd_reg1_strb = 4'b0001; rd_mem = 1; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_loaded got %b exp 1", stall); end
    idle(); flush = 1; iss_valid = 1; iss_ld_seg = 1; iss_seg_id = 5; cycle();
    idle(); rd_reg1_en = 1; rd_reg1_id = 0; rd_reg1_strb = 4'b0001; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_gpr got %b exp 0", stall); end
    idle(); rd_mem = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_mem got %b exp 0", stall); end
    idle(); rd_seg_en = 1; rd_seg_id = 5; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_issue_dropped got %b exp 0", stall); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      iss_valid = ($urandom_range(0, 9) < 6);
      {iss_ld_reg1, iss_ld_reg2, iss_ld_reg3} = 3'($urandom);
      iss_reg1_id = 3'($urandom_range(0, 3)); iss_reg2_id = 3'($urandom_range(0, 3)); iss_reg3_id = 3'($urandom_range(0, 3));
      iss_reg1_strb = 4'($urandom); iss_reg2_strb = 4'($urandom); iss_reg3_strb = 4'($urandom);
      iss_ld_seg = 1'($urandom); iss_seg_id = 3'($urandom_range(0, 3));
      iss_ld_mm = 1'($urandom); iss_mm_id = 3'($urandom_range(0, 3));
      iss_ld_mem = ($urandom_range(0, 3) == 0); iss_ld_flag = 4'($urandom) & 4'($urandom);
      {rd_reg1_en, rd_reg2_en, rd_seg_en, rd_mm1_en, rd_mm2_en} = 5'($urandom) & 5'($urandom);
      rd_reg1_id = 3'($urandom_range(0, 3)); rd_reg2_id = 3'($urandom_range(0, 3));
      rd_reg1_strb = 4'($urandom); rd_reg2_strb = 4'($urandom);
      rd_seg_id = 3'($urandom_range(0, 3)); rd_mm1_id = 3'($urandom_range(0, 3)); rd_mm2_id = 3'($urandom_range(0, 3));
      rd_mem = ($urandom_range(0, 3) == 0); rd_flag = 4'($urandom) & 4'($urandom);
      wb_valid = 1;
      {wb_ld_reg1, wb_ld_reg2, wb_ld_reg3} = 3'($urandom);
      wb_reg1_id = 3'($urandom_range(0, 3)); wb_reg2_id = 3'($urandom_range(0, 3)); wb_reg3_id = 3'($urandom_range(0, 3));
      wb_reg1_strb = 4'($urandom); wb_reg2_strb = 4'($urandom); wb_reg3_strb = 4'($urandom);
      wb_ld_seg = 1'($urandom); wb_seg_id = 3'($urandom_range(0, 3));
      wb_ld_mm = 1'($urandom); wb_mm_id = 3'($urandom_range(0, 3));
      wb_ld_mem = 1'($urandom); wb_ld_flag = 4'($urandom);
      if (would_underflow()) wb_valid = 0;
      flush = ($urandom_range(0, 39) == 0);
      #1;
      tests++; if (stall !== exp_stall()) begin fails++; $display("FAIL rand_stall[%0d] got %b exp %b", n, stall, exp_stall()); end
      tests++; if (iss_ack !== (iss_valid && !exp_stall())) begin fails++; $display("FAIL rand_ack[%0d] got %b exp %b", n, iss_ack, iss_valid && !exp_stall()); end
      tests++; if (sb_err !== err) begin fails++; $display("FAIL rand_sb_err[%0d] got %b exp %b", n, sb_err, err); end
      cycle();
    end
    idle();
  endtask

  task automatic test_async_reset();
    iss_valid = 1; iss_ld_reg2 = 1; iss_reg2_id = 6; iss_reg2_strb = 4'b1000; cycle();
    idle(); rd_reg2_en = 1; rd_reg2_id = 6; rd_reg2_strb = 4'b1000; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL areset_loaded got %b exp 1", stall); end
    #1; rst_n = 0; clear_model(); err = 0; #1;
    tests++; if (stall !== 1'b0 || sb_err !== 1'b0) begin fails++; $display("FAIL areset_clear got stall=%b err=%b exp 0/0", stall, sb_err); end
    iss_valid = 1; iss_ld_reg2 = 1; wb_valid = 1; wb_ld_seg = 1; wb_seg_id = 1;
    @(posedge clk); @(negedge clk); rst_n = 1; idle();
    rd_reg2_en = 1; rd_reg2_id = 6; rd_reg2_strb = 4'b1000; #1;
    tests++; if (stall !== 1'b0 || sb_err !== 1'b0) begin fails++; $display("FAIL areset_ignored got stall=%b err=%b exp 0/0", stall, sb_err); end
    idle();
  endtask

  initial begin
    test_reset();
    test_gpr_raw();
    test_flag_same_cycle();
    test_saturation();
    test_sb_err();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
